// File: rtl/conv_frame_ctrl_if.sv
// Pixel-in / result-out stream bundle between the frame sequencer and its producer/consumer.
// The sequencer takes the slave view; the pixel source and result sink together take the master view.
interface conv_frame_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for a streaming KxK convolution core: walks one NxN raster frame,
// clears the core per frame and qualifies core results whose window lies fully inside the frame.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one cycle of core clear, no pixels accepted
// RUN   | accepting pixels, tracking row/col, presenting qualified results
// DRAIN | last pixel taken, waiting for the final result to retire
// DONE  | one-cycle done pulse
module conv_frame_ctrl #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int K_SIZE     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  conv_en_o,
    output logic                  conv_rst_o,
    output logic [DATA_WIDTH-1:0] conv_data_o,
    input  logic [DATA_WIDTH-1:0] conv_result_i,
    conv_frame_ctrl_if.slave      strm
);

    localparam int             CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0]  WIN_IDX  = CW'(K_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic            m_valid_q;
    logic            m_last_q;
    logic            busy_q;
    logic            done_q;
    logic            conv_rst_q;

    logic            s_ready;
    logic            accept;
    logic            frame_end;
    logic            win_ok;

    // A held result freezes the core by refusing pixels, so m_data stays stable.
    assign s_ready   = (state_q == RUN) && (!m_valid_q || strm.m_ready);
    assign accept    = strm.s_valid && s_ready;
    assign frame_end = (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign win_ok    = (row_q >= WIN_IDX) && (col_q >= WIN_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conv_rst_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            conv_rst_q <= 1'b0;

            // An accept while a result is held implies m_ready, so the old beat retires here.
            if (accept) begin
                m_valid_q <= win_ok;
                m_last_q  <= win_ok && frame_end;
            end else if (strm.m_ready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q    <= CLEAR;
                        busy_q     <= 1'b1;
                        conv_rst_q <= 1'b1;
                        row_q      <= '0;
                        col_q      <= '0;
                    end
                end
                CLEAR: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (accept) begin
                        if (frame_end) begin
                            row_q   <= '0;
                            col_q   <= '0;
                            state_q <= DRAIN;
                        end else if (col_q == LAST_IDX) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!m_valid_q || strm.m_ready) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign conv_rst_o   = conv_rst_q;
    assign conv_en_o    = accept;
    assign conv_data_o  = strm.s_data;
    assign strm.s_ready = s_ready;
    assign strm.m_valid = m_valid_q;
    assign strm.m_last  = m_last_q;
    assign strm.m_data  = conv_result_i;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl (N=4, K=3): the core is stood in for by a running-sum register
// cleared by conv_rst, so each result encodes which pixels reached the core since the last clear.
module tb_conv_frame_ctrl;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int K  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, conv_en, conv_rst;
    logic [DW-1:0] conv_data, conv_result;
    logic [DW-1:0] core_acc = '0;

    conv_frame_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    conv_frame_ctrl #(.N(N), .DATA_WIDTH(DW), .K_SIZE(K)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .busy_o        (busy),
        .done_o        (done),
        .conv_en_o     (conv_en),
        .conv_rst_o    (conv_rst),
        .conv_data_o   (conv_data),
        .conv_result_i (conv_result),
        .strm          (bus.slave)
    );

    always #5 clk = ~clk;

    // Stand-in core: result reflects the pixel accepted at the same edge, one cycle after acceptance.
    always @(posedge clk) begin
        if (conv_rst)     core_acc <= '0;
        else if (conv_en) core_acc <= core_acc + conv_data;
    end
    assign conv_result = core_acc;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            pix, budget, stall_left, stall_cyc, hold_bad;
    int            done_cnt, clr_cnt, en_cnt, en_bad, data_bad;
    int            done_cyc, beat_cyc, total_beats;
    bit            acc_flag, start_done;
    logic          sr_s;
    logic [DW-1:0] md_s, held;
    logic [DW-1:0] res_q[$];
    logic          last_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        acc_flag = bus.s_valid && bus.s_ready;
        sr_s     = bus.s_ready;
        md_s     = bus.m_data;
        if (conv_en !== acc_flag) en_bad++;
        if (conv_data !== bus.s_data) data_bad++;
        if (conv_en) en_cnt++;
        if (bus.m_valid && bus.m_ready) begin
            res_q.push_back(bus.m_data);
            last_q.push_back(bus.m_last);
            beat_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (conv_rst) clr_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int base, input bit toggle, input int stall_len,
                             input int start_at, input int rst_at);
        pix = 0; budget = 0; stall_left = stall_len; stall_cyc = 0; hold_bad = 0;
        done_cnt = 0; clr_cnt = 0; en_cnt = 0; en_bad = 0; data_bad = 0;
        start_done = 1'b0; held = '0;
        res_q.delete(); last_q.delete();
        bus.s_valid = 1'b0; bus.m_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        while (done_cnt == 0 && budget < 300) begin
            if (pix == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_m_valid", bus.m_valid, 0);
                chk("rst_mid_row_col", {dut.row_q, dut.col_q}, 0);
                bus.s_valid = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            bus.s_valid = (pix < N*N) && (!toggle || (budget % 2 == 0));
            bus.s_data  = DW'(base + pix);
            if (stall_left > 0 && bus.m_valid) begin
                bus.m_ready = 1'b0;
                if (stall_cyc == 0) held = bus.m_data;
            end else begin
                bus.m_ready = 1'b1;
            end
            if (pix == start_at && !start_done) begin
                start_done = 1'b1;
                start = 1'b1;
                chk("start_pre_row_col", {dut.row_q, dut.col_q}, {2'd1, 2'd2});
            end
            step();
            if (!bus.m_ready) begin
                stall_left--;
                stall_cyc++;
                if (sr_s !== 1'b0 || md_s !== held) hold_bad++;
            end
            if (start) begin
                start = 1'b0;
                chk("start_post_row_col", {dut.row_q, dut.col_q}, {2'd1, 2'd3});
            end
            if (acc_flag) pix++;
            budget++;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        chk("frame_in_budget", 32'(budget < 300), 1);
    endtask

    task automatic check_res(input string tag, input int e0, input int e1, input int e2, input int e3);
        int          exp_v[4];
        logic [3:0]  lv;
        exp_v = '{e0, e1, e2, e3};
        total_beats += res_q.size();
        chk({tag, "_beats"}, res_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_res%0d", tag, i), (i < res_q.size()) ? 32'(res_q[i]) : 'x, exp_v[i]);
            lv[i] = (i < last_q.size()) ? last_q[i] : 1'bx;
        end
        chk({tag, "_m_last"}, lv, 4'b1000);
        chk({tag, "_clear_cycles"}, clr_cnt, 1);
    endtask

    initial begin
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h00AA;
        bus.m_ready = 1'b1;
        start       = 1'b0;
        #3;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_m_valid", bus.m_valid, 0);
        chk("reset_m_last", bus.m_last, 0);
        chk("reset_s_ready", bus.s_ready, 0);
        chk("reset_conv_en", conv_en, 0);
        chk("reset_conv_rst", conv_rst, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.s_valid = 1'b0;
        step();

        // Plain frame: results after pixels 10, 11, 14, 15 are prefix sums 0..10, 0..11, 0..14, 0..15.
        total_beats = 0;
        run_frame(0, 1'b0, 0, -1, -1);
        check_res("s1", 55, 66, 105, 120);
        chk("s1_done_after_last", done_cyc, beat_cyc + 1);
        chk("s1_conv_en_cnt", en_cnt, 16);
        chk("s1_conv_en_match", en_bad, 0);
        chk("s1_conv_data_pass", data_bad, 0);
        chk("s1_idle_after", busy, 0);

        run_frame(0, 1'b0, 5, -1, -1);
        check_res("s2", 55, 66, 105, 120);
        chk("s2_stall_cycles", stall_cyc, 5);
        chk("s2_hold_stable", hold_bad, 0);

        run_frame(0, 1'b1, 0, -1, -1);
        check_res("s3", 55, 66, 105, 120);
        chk("s3_conv_en_cnt", en_cnt, 16);
        chk("s3_conv_en_match", en_bad, 0);

        run_frame(0, 1'b0, 0, 6, -1);
        for (int i = 0; i < 3; i++) step();
        chk("s4_single_done", done_cnt, 1);
        check_res("s4", 55, 66, 105, 120);

        // Mid-frame reset leaves 0..8 in the core; the next frame's CLEAR must wipe it.
        run_frame(0, 1'b0, 0, -1, 9);
        chk("s5_no_partial_results", res_q.size(), 0);
        chk("s5_no_done", done_cnt, 0);
        run_frame(0, 1'b0, 0, -1, -1);
        check_res("s5", 55, 66, 105, 120);

        total_beats = 0;
        run_frame(0, 1'b0, 0, -1, -1);
        check_res("s6a", 55, 66, 105, 120);
        run_frame(100, 1'b0, 0, -1, -1);
        check_res("s6b", 1155, 1266, 1605, 1720);
        chk("s6_total_beats", total_beats, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
